// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: freezes on memory stalls, flushes on taken branches
// (including ones seen while frozen), inserts load-use bubbles, and counts stall/flush cycles.
module hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_memread,
  input  logic              ex_br_taken,
  input  logic              mem_busy,
  input  logic              cnt_clr,
  output logic              pc_en,
  output logic [1:0]        ifid_sel,
  output logic [1:0]        idex_sel,
  output logic [1:0]        state_o,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    MEMWAIT = 2'b01
  } state_t;

  localparam logic [1:0]       SEL_ADV   = 2'b00;
  localparam logic [1:0]       SEL_HOLD  = 2'b01;
  localparam logic [1:0]       SEL_FLUSH = 2'b11;
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state_q, state_d;
  logic   pend_q, pend_d;
  logic   load_use;
  logic   flush_req;

  assign load_use = ex_memread && (ex_rd != '0) &&
                    ((id_use_rs1 && (ex_rd == id_rs1)) ||
                     (id_use_rs2 && (ex_rd == id_rs2)));

  // A branch that resolved while frozen must still flush once the pipeline thaws.
  assign flush_req = ex_br_taken | pend_q;

  always_comb begin
    state_d  = RUN;
    pend_d   = 1'b0;
    pc_en    = 1'b1;
    ifid_sel = SEL_ADV;
    idex_sel = SEL_ADV;
    if (i_rst) begin
      state_d = RUN;
    end else if (mem_busy) begin
      pc_en    = 1'b0;
      ifid_sel = SEL_HOLD;
      idex_sel = SEL_HOLD;
      state_d  = MEMWAIT;
      pend_d   = pend_q | ex_br_taken;
    end else if (flush_req) begin
      ifid_sel = SEL_FLUSH;
      idex_sel = SEL_FLUSH;
    end else if (load_use) begin
      pc_en    = 1'b0;
      ifid_sel = SEL_HOLD;
      idex_sel = SEL_FLUSH;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= RUN;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  // Unused encodings report as RUN.
  assign state_o = (state_q == MEMWAIT) ? MEMWAIT : RUN;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_ONE;
      if ((ifid_sel == SEL_FLUSH) && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, meaning register-address width.
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of each performance counter.
REQ-003 SHALL have port i_clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port id_rs1  input  REG_AW  rs1 address of the instruction in ID.
REQ-006 SHALL have port id_rs2  input  REG_AW  rs2 address of the instruction in ID.
REQ-007 SHALL have port id_use_rs1  input  1  ID instruction reads rs1.
REQ-008 SHALL have port id_use_rs2  input  1  ID instruction reads rs2.
REQ-009 SHALL have port ex_rd  input  REG_AW  destination register of the instruction in EX.
REQ-010 SHALL have port ex_memread  input  1  EX instruction is a load.
REQ-011 SHALL have port ex_br_taken  input  1  branch/jump resolved taken in EX.
REQ-012 SHALL have port mem_busy  input  1  data memory/peripheral not ready; pipeline must freeze.
REQ-013 SHALL have port cnt_clr  input  1  synchronous clear of both counters.
REQ-014 SHALL have port pc_en  output  1  PC register advances when 1.
REQ-015 SHALL have port ifid_sel  output  2  IF/ID control: 00 advance, 01 hold, 11 flush.
REQ-016 SHALL have port idex_sel  output  2  ID/EX control: 00 advance, 01 hold, 11 flush (bubble).
REQ-017 SHALL have port state_o  output  2  current FSM state encoding.
REQ-018 SHALL have port stall_cnt  output  CNT_W  cycles with pc_en=0.
REQ-019 SHALL have port flush_cnt  output  CNT_W  cycles with ifid_sel=11.

Function
REQ-020 SHALL implement FSM states RUN (00) and MEMWAIT (01); encodings 10/11 unused and SHALL decode to RUN.
REQ-021 SHALL hold a 1-bit pend_flush register recording a taken branch seen while frozen.
REQ-022 SHALL define load_use = ex_memread & (ex_rd!=0) & ((id_use_rs1 & ex_rd==id_rs1) | (id_use_rs2 & ex_rd==id_rs2)).
REQ-023 SHALL define flush_req = ex_br_taken | pend_flush.
REQ-024 SHALL, when mem_busy=1 in either state: pc_en=0, ifid_sel=01, idex_sel=01; next state MEMWAIT; pend_flush <= pend_flush | ex_br_taken.
REQ-025 SHALL, when mem_busy=0 and flush_req=1: pc_en=1, ifid_sel=11, idex_sel=11 (flush beats load_use).
REQ-026 SHALL, when mem_busy=0, flush_req=0, load_use=1: pc_en=0, ifid_sel=01, idex_sel=11.
REQ-027 SHALL, when mem_busy=0, flush_req=0, load_use=0: pc_en=1, ifid_sel=00, idex_sel=00.
REQ-028 SHALL, on any cycle with mem_busy=0: next state RUN and pend_flush <= 0.
REQ-029 SHALL drive pc_en, ifid_sel, idex_sel combinationally from current state/pend_flush and current inputs (zero-cycle latency).
REQ-030 SHALL never output 10 on ifid_sel or idex_sel.
REQ-031 SHALL increment stall_cnt each cycle pc_en=0 and flush_cnt each cycle ifid_sel=11, each saturating at all-ones.
REQ-032 SHALL give cnt_clr priority over increment; cleared counter reads 0 next cycle.

Reset
REQ-033 SHALL on i_rst=1, asynchronously and independent of i_clk, force state RUN, pend_flush=0, stall_cnt=0, flush_cnt=0.
REQ-034 SHALL, while i_rst=1, drive pc_en=1, ifid_sel=00, idex_sel=00, state_o=00.
REQ-035 SHALL, on reset asserted mid-MEMWAIT with pend_flush=1, discard the pending flush; first cycle after release behaves as RUN with pend_flush=0.

Verification
REQ-036 SHALL verify load-use: ex_memread=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> pc_en=0, ifid_sel=01, idex_sel=11, stall_cnt +1; same with ex_rd=0 -> 1/00/00.
REQ-037 SHALL verify branch flush: ex_br_taken=1 alongside load_use=1 -> pc_en=1, ifid_sel=11, idex_sel=11, flush_cnt +1, stall_cnt unchanged.
REQ-038 SHALL verify freeze with pending flush: mem_busy=1 for 3 cycles, ex_br_taken pulsed in cycle 2 only -> 3 cycles 0/01/01, state_o=01; cycle 4 (busy=0, br=0) -> 1/11/11, then state_o=00, pend_flush=0.
REQ-039 SHALL verify saturation: CNT_W=4, hold mem_busy=1 for 20 cycles -> stall_cnt stops at 15; cnt_clr with mem_busy=1 -> stall_cnt=0 next cycle.
REQ-040 SHALL verify async reset: assert i_rst between clock edges during MEMWAIT with pend_flush=1 -> state_o=00 and counters 0 immediately; after release with busy=0, br=0 -> 1/00/00.
